// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for a common-anode 7-segment bank.
//   Steps through NDIG digits, one slot of DIV clocks each, through a shared BCD decoder.
//   The first GUARD clocks of each slot are blanked to avoid ghosting.
//   Display data is double-buffered: LOAD fills a pending buffer, and that buffer is
//   promoted to the active buffer only at the frame boundary (idx wraps NDIG-1 -> 0).
//   Outputs are registered and reflect the scan/active state one cycle earlier.
// Ports:
//   CLK, RST (sync, active-high)
//   VAL/DP_POS/OVF + LOAD strobe  : display data capture
//   DP_EN, LZ_EN                  : live decimal-point / leading-zero-suppression enables
//   S, DP                         : decoder code and DP control (DP=0 lights the point)
//   AN                            : active-low digit enables
//   FRAME                         : one-cycle pulse after each frame boundary
module disp_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 50000,
  parameter int GUARD = 500
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [4*NDIG-1:0]        VAL,
  input  logic                     LOAD,
  input  logic [$clog2(NDIG)-1:0]  DP_POS,
  input  logic                     DP_EN,
  input  logic                     LZ_EN,
  input  logic                     OVF,
  output logic [3:0]               S,
  output logic                     DP,
  output logic [NDIG-1:0]          AN,
  output logic                     FRAME
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);
  localparam logic [3:0]    DASH    = 4'b1010;

  // Scan state
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;

  // Pending and active display buffers
  logic                pend_q, pend_d;
  logic [4*NDIG-1:0]   pval_q, pval_d;
  logic [IW-1:0]       pdp_q, pdp_d;
  logic                povf_q, povf_d;
  logic [4*NDIG-1:0]   aval_q, aval_d;
  logic [IW-1:0]       adp_q, adp_d;
  logic                aovf_q, aovf_d;

  // Registered outputs
  logic [3:0]          s_q, s_d;
  logic                dp_q, dp_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic                frame_q, frame_d;

  logic                tick;
  logic                boundary;
  logic                zero_run;
  logic                cur_sup;
  logic [3:0]          cur_dig;
  logic                blank;

  always_comb begin
    // Prescaler and digit index
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // Buffering: a LOAD coinciding with the boundary bypasses the pending
    // buffer and lands directly in the active buffer.
    pend_d = pend_q;
    pval_d = pval_q;
    pdp_d  = pdp_q;
    povf_d = povf_q;
    aval_d = aval_q;
    adp_d  = adp_q;
    aovf_d = aovf_q;
    if (boundary) begin
      if (LOAD) begin
        aval_d = VAL;
        adp_d  = DP_POS;
        aovf_d = OVF;
      end else if (pend_q) begin
        aval_d = pval_q;
        adp_d  = pdp_q;
        aovf_d = povf_q;
      end
      pend_d = 1'b0;
    end else if (LOAD) begin
      pval_d = VAL;
      pdp_d  = DP_POS;
      povf_d = OVF;
      pend_d = 1'b1;
    end

    // Walk digits from the most significant end; zero_run stays set while
    // every digit from NDIG-1 down to i is zero. Only the currently scanned
    // digit's code and suppression state are kept.
    zero_run = 1'b1;
    cur_sup  = 1'b0;
    cur_dig  = 4'h0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run = zero_run && (aval_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        cur_dig = aval_q[4*i +: 4];
        cur_sup = LZ_EN && !aovf_q && zero_run && (i != 0) && (IW'(i) > adp_q);
      end
    end

    blank = (cnt_q < GUARD_C) || cur_sup;

    an_d = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (!blank && (idx_q == IW'(i))) begin
        an_d[i] = 1'b0;
      end
    end

    s_d     = aovf_q ? DASH : cur_dig;
    dp_d    = !(DP_EN && (idx_q == adp_q) && !aovf_q);
    frame_d = boundary;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      pdp_q   <= '0;
      povf_q  <= 1'b0;
      aval_q  <= '0;
      adp_q   <= '0;
      aovf_q  <= 1'b0;
      s_q     <= 4'h0;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      pdp_q   <= pdp_d;
      povf_q  <= povf_d;
      aval_q  <= aval_d;
      adp_q   <= adp_d;
      aovf_q  <= aovf_d;
      s_q     <= s_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign S     = s_q;
  assign DP    = dp_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the frequency counter's common-anode 7-segment display bank.
- Cycles one digit at a time through a shared BCD-to-segment decoder. Drives the decoder's 4-bit code (S) and decimal-point control (DP), plus active-low digit enables.
- Double-buffers the counter result so a display update lands only on a frame boundary (no tearing).
- Adds leading-zero suppression, decimal-point placement, an overflow "dash" display and an anti-ghosting guard interval.

Parameters:
- NDIG, 8, number of digits; digit 0 is least significant (rightmost).
- DIV, 50000, clock cycles per digit slot (refresh prescaler), must be >= GUARD+2.
- GUARD, 500, cycles at the start of each slot during which all digits are blanked.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- VAL  in  4*NDIG  BCD digits; VAL[4i+3:4i] is digit i.
- LOAD  in  1  one-cycle strobe: capture VAL/DP_POS/OVF as pending display data.
- DP_POS  in  clog2(NDIG)  digit index carrying the decimal point.
- DP_EN  in  1  1 = show the decimal point at DP_POS.
- LZ_EN  in  1  1 = enable leading-zero suppression.
- OVF  in  1  1 = overflow; show all digits as dash (code 4'b1010).
- S  out  4  BCD code to decoder.
- DP  out  1  decoder DP control: 0 = point lit, 1 = point off.
- AN  out  NDIG  digit enables, active-low.
- FRAME  out  1  one-cycle pulse when the scan wraps and the active buffer updates.

Behaviour:

Reset:
- One clock; reset is synchronous and active-high, on CLK/RST.
- RST=1 at a rising edge sets: cnt=0, idx=0, pending flag=0, pending and active buffers all zero (VAL=0, DP_POS=0, OVF=0); S=4'b0000, DP=1, AN=all 1s, FRAME=0.
- RST mid-scan aborts the slot; the scan restarts at digit 0 and any pending LOAD is discarded.

Prescaler and scan:
- cnt counts 0..DIV-1 and wraps; tick = (cnt==DIV-1).
- On tick, idx increments; from NDIG-1 it wraps to 0.
- Wrap of idx from NDIG-1 to 0 is the frame boundary.

Buffering:
- LOAD=1 copies VAL/DP_POS/OVF into the pending buffer and sets pending=1. A later LOAD before the boundary overwrites it; the last LOAD wins.
- At the frame boundary with pending=1: active buffer <= pending buffer, pending <= 0.
- LOAD in the same cycle as the boundary: the values presented that cycle go straight to active, and pending ends at 0.
- FRAME=1 for exactly the cycle after every boundary, regardless of pending.

Outputs:
- All outputs are registered, computed from the cnt/idx/active state of the previous cycle (1-cycle latency).
- Blank condition = (cnt < GUARD) OR digit idx is suppressed. When blanked, AN is all 1s; otherwise AN = ~(1<<idx).
- S = 4'b1010 if active OVF, else active digit idx.
- DP = 0 iff DP_EN=1 and idx==active DP_POS and OVF=0; otherwise DP = 1.

Leading-zero suppression:
- Applies only when LZ_EN=1 and OVF=0.
- Digit i is suppressed iff i > DP_POS, i != 0, and all active digits NDIG-1..i equal 0.
- Digit 0 and digits at or below DP_POS are never suppressed.

Other rules:
- Digit codes above 4'b1010 are passed through unchanged; the decoder handles them.
- DP_EN and LZ_EN are sampled live, not buffered.

Test Plan (NDIG=4, DIV=4, GUARD=1):
1. Reset then idle → AN=1111 for cycles 0-1 after RST release. At cycle 2, AN=1110, S=0, DP=1. Slots advance every 4 cycles in the order 1110, 1101, 1011, 0111, 1110. AN=1111 in the first cycle of every slot.
2. LOAD with VAL=16'h1234, DP_EN=1, DP_POS=2 at mid-frame → display unchanged until the boundary. FRAME pulses one cycle. The next frame shows S=4,3,2,1 for digits 0..3, with DP=0 only on digit 2.
3. Two LOADs (16'h1111, then 16'h2222) within one frame → only 16'h2222 is displayed after the boundary. LOAD coincident with the boundary → that cycle's VAL is shown the next frame.
4. LZ_EN=1, VAL=16'h0050, DP_EN=0, DP_POS=0 → digits 3 and 2 stay blank (AN never 0111 or 1011). Digits 1 and 0 show 5 and 0. With VAL=16'h0000, only digit 0 lights.
5. OVF=1 loaded with LZ_EN=1 → all four digits lit with S=4'b1010 and DP=1 throughout.
6. RST asserted mid-slot on digit 2 with a LOAD pending → the next cycle has AN=1111, S=0, DP=1. The scan restarts at digit 0 showing zeros, and the pending data never appears.
